word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-to-serial transmitter, the reader side of per-bit vector writers in the frontend for/generate regression designs.
- Accepts one WIDTH-bit word on a valid/ready handshake and emits it one bit per cycle, LSB first, on a valid/ready serial port.
- Also reports the captured word's population count.
- Used in regression benches that check for-loop variable scoping, including `int`/`int unsigned`/`genvar` loop declarations and named generate blocks, in sequential logic.

Parameters:
- WIDTH, 8, data word width; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of bit index and popcount fields (derived, not overridable).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  parallel word.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  downstream consumes ser_bit this cycle.
- ser_bit  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the frame.
- ones  output  CNT_W  number of 1 bits in the most recently accepted word.
- busy  output  1  frame in progress.

Behaviour:
- States: IDLE, SHIFT.
- Reset: state=IDLE, in_ready=1, ser_valid=0, ser_bit=0, ser_last=0, ones=0, busy=0, shift register=0, index=0.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&&in_ready: capture in_data into the shift register, index=0, go to SHIFT next cycle.
  - ones is updated in the same edge, computed by a procedural for loop with a loop-local `int` variable.
- SHIFT:
  - in_ready=0, busy=1, ser_valid=1, ser_bit=shreg[0].
  - ser_last=1 when index==WIDTH-1 (no parity).
- Serial handshake:
  - A bit transfers on ser_valid&&ser_ready.
  - On transfer: shreg shifts right by one (zero fill) and index increments.
  - ser_ready low holds ser_bit, ser_last and index stable for any number of cycles.
- Frame end: when the last bit transfers, go to IDLE and drop ser_valid next cycle.
- No back-to-back overlap: in_ready rises the cycle after the last transfer, so there is at least one idle cycle between frames.
- Latency: word accepted at edge N; first bit valid in cycle N+1; minimum frame length WIDTH cycles with ser_ready held high.
- in_valid while busy is ignored; in_data is not sampled.
- Registered outputs: ser_bit, ser_last and ser_valid are registered; in_ready and busy decode state only. There are no combinational paths from inputs to outputs.
- Per-bit debug taps: a named generate loop `tap[g]`, g=0..WIDTH-1, declares wire `b` equal to the captured word bit g. The taps hold until the next capture and are accessible hierarchically as tap[g].b.
- Reset mid-frame: the frame is abandoned. The next cycle shows the reset values, and no further bits of the old word appear.
- Width rules:
  - index counts 0..WIDTH-1 and never wraps within a frame.
  - ones saturates nowhere; max value is WIDTH, and it fits CNT_W.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the captured word) is emitted.
  - ser_last is asserted only on the parity bit; the frame is WIDTH+1 bits.
  - The index range extends to WIDTH.
- Undefined: frames are exactly WIDTH bits and no parity logic is built.

Test Plan:
- Reset, then in_data=8'hA5 with in_valid=1 and ser_ready=1 → next 8 ser_bit values are 1,0,1,0,0,1,0,1; ser_last=1 only on the 8th; ones=4; in_ready returns 1 the cycle after.
- Same word with ser_ready toggling 1,0,0,1,... → the bit sequence is unchanged and ser_bit holds while ser_ready=0; total frame length is 8 plus the stall cycles.
- in_valid asserted with 8'hFF during a frame of 8'h00 → the frame emits eight 0s, then stays IDLE; ones stays 0 until 8'hFF is offered again while in_ready=1, after which ones=8.
- rst pulsed after 3 bits of 8'h0F → ser_valid=0, ones=0, busy=0 the next cycle; a new word 8'h80 then emits seven 0s and a final 1.
- Check tap[0].b..tap[7].b against the captured word 8'h3C via hierarchical reference after capture → taps read 0,0,1,1,1,1,0,0.
- With WORD_SERIALIZER_PARITY_EN defined and in_data=8'h07 → 9 bits: 1,1,1,0,0,0,0,0,1; ser_last on the 9th bit only.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: accepts one WIDTH-bit word on a valid/ready handshake and
// shifts it out LSB first on a valid/ready serial port, one bit per cycle.
// The population count of the most recently captured word is reported on ones.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN appends an even-parity bit
// (XOR of the captured word) after the data bits; ser_last then marks only
// the parity bit.

module word_serializer #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic [CNT_W-1:0] ones,
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_bit_q, ser_bit_d;
    logic             ser_last_q, ser_last_d;
    logic [WIDTH-1:0] tap_word;
    logic [CNT_W-1:0] ones_cnt;
    logic             xfer;

    // Debug taps: one wire per captured word bit, held until the next capture.
    for (genvar g = 0; g < WIDTH; g++) begin : tap
        wire b;
        assign b           = word_q[g];
        assign tap_word[g] = b;
    end

    // Population count of the captured word; it changes on the capture edge.
    always_comb begin
        ones_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + CNT_W'(tap_word[i]);
        end
    end

    assign xfer = ser_valid_q && ser_ready;

    // Next-state logic for the frame FSM, shift register and serial outputs.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        word_d      = word_q;
        idx_d       = idx_q;
        ser_valid_d = ser_valid_q;
        ser_bit_d   = ser_bit_q;
        ser_last_d  = ser_last_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = SHIFT;
                    shreg_d     = in_data;
                    word_d      = in_data;
                    idx_d       = '0;
                    ser_valid_d = 1'b1;
                    ser_bit_d   = in_data[0];
                    ser_last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`ifdef WORD_SERIALIZER_PARITY_EN
                    // After the last data bit, the parity bit takes bit 0.
                    if (idx_q == CNT_W'(WIDTH - 1)) begin
                        shreg_d[0] = ^tap_word;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        ser_valid_d = 1'b0;
                        ser_bit_d   = 1'b0;
                        ser_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + CNT_W'(1);
                        ser_bit_d  = shreg_d[0];
                        ser_last_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                ser_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            ser_valid_q <= ser_valid_d;
            ser_bit_q   <= ser_bit_d;
            ser_last_q  <= ser_last_d;
        end
    end

    // Output decode: handshake flags from state, serial outputs from registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SHIFT);
        ser_valid = ser_valid_q;
        ser_bit   = ser_bit_q;
        ser_last  = ser_last_q;
        ones      = ones_cnt;
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed self-checking bench for word_serializer (WIDTH=8).
// Covers WORD_SERIALIZER_PARITY_EN builds by extending the expected frames.

module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_bit;
    logic       ser_last;
    logic [3:0] ones;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0] bits;
    logic [8:0] lasts;
    int         nbits;
    int         cycles;
    logic [7:0] tapv;
    logic [8:0] exp_lasts;

    word_serializer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ser_valid(ser_valid),
        .ser_ready(ser_ready),
        .ser_bit  (ser_bit),
        .ser_last (ser_last),
        .ones     (ones),
        .busy     (busy)
    );

    assign tapv = {dut.tap[7].b, dut.tap[6].b, dut.tap[5].b, dut.tap[4].b,
                   dut.tap[3].b, dut.tap[2].b, dut.tap[1].b, dut.tap[0].b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] frame_of(input logic [7:0] w);
`ifdef WORD_SERIALIZER_PARITY_EN
        return {^w, w};
`else
        return {1'b0, w};
`endif
    endfunction

    // Called at a negedge; leaves in_valid low and returns at the negedge after capture.
    task automatic send(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collects one frame at negedges; optional 1,0,0 ready pattern with hold checks.
    task automatic collect(input bit stall, output logic [8:0] b, output logic [8:0] l,
                           output int n, output int cyc);
        bit   ready;
        bit   held;
        bit   done;
        logic hb;
        b    = '0;
        l    = '0;
        n    = 0;
        cyc  = 0;
        held = 1'b0;
        done = 1'b0;
        hb   = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (!ser_valid) begin
                if (n > 0) begin
                    done = 1'b1;
                    check("in_ready_after_frame", in_ready, 1);
                end
            end else begin
                if (held) check("hold_bit", ser_bit, hb);
                ready = stall ? (cyc % 3 == 0) : 1'b1;
                ser_ready = ready;
                if (ready) begin
                    if (n < 9) begin
                        b[n] = ser_bit;
                        l[n] = ser_last;
                    end
                    n++;
                    if (ser_last) in_valid = 1'b0;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hb   = ser_bit;
                end
                cyc++;
            end
            if (!done) @(negedge clk);
        end
        if (!done) check("frame_timeout", 0, 1);
        ser_ready = 1'b1;
    endtask

    initial begin
        exp_lasts = 9'd1 << (FL - 1);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ser_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_ser_last", ser_last, 0);
        check("rst_ones", ones, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // A5 with ready held high.
        send(8'hA5);
        check("a5_busy", busy, 1);
        check("a5_in_ready", in_ready, 0);
        check("a5_first_valid", ser_valid, 1);
        check("a5_first_bit", ser_bit, 1);
        check("a5_ones", ones, 4);
        collect(1'b0, bits, lasts, nbits, cycles);
        check("a5_nbits", nbits, FL);
        check("a5_bits", bits, frame_of(8'hA5));
        check("a5_lasts", lasts, exp_lasts);
        check("a5_cycles", cycles, FL);

        // A5 with stalls: 1,0,0 ready pattern.
        send(8'hA5);
        collect(1'b1, bits, lasts, nbits, cycles);
        check("stall_nbits", nbits, FL);
        check("stall_bits", bits, frame_of(8'hA5));
        check("stall_lasts", lasts, exp_lasts);
        check("stall_cycles", cycles, 3 * (FL - 1) + 1);

        // FF offered while a frame of 00 is in flight is ignored.
        send(8'h00);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        collect(1'b0, bits, lasts, nbits, cycles);
        check("ign_bits", bits, frame_of(8'h00));
        check("ign_nbits", nbits, FL);
        check("ign_ones", ones, 0);
        repeat (2) @(negedge clk);
        check("ign_idle_busy", busy, 0);
        check("ign_idle_valid", ser_valid, 0);
        check("ign_idle_ones", ones, 0);
        send(8'hFF);
        check("ff_ones", ones, 8);
        collect(1'b0, bits, lasts, nbits, cycles);
        check("ff_bits", bits, frame_of(8'hFF));

        // Reset after three bits of 0F.
        send(8'h0F);
        for (int i = 0; i < 3; i++) begin
            check("rstmid_pre_bit", ser_bit, 1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_valid", ser_valid, 0);
        check("rstmid_ones", ones, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_bit", ser_bit, 0);
        check("rstmid_in_ready", in_ready, 1);
        @(negedge clk);
        check("rstmid_stay_idle", ser_valid, 0);
        send(8'h80);
        collect(1'b0, bits, lasts, nbits, cycles);
        check("w80_bits", bits, frame_of(8'h80));
        check("w80_lasts", lasts, exp_lasts);
        check("w80_nbits", nbits, FL);

        // Debug taps after capturing 3C.
        send(8'h3C);
        check("taps_3c", tapv, 8'h3C);
        check("tap0", dut.tap[0].b, 0);
        check("tap2", dut.tap[2].b, 1);
        check("tap7", dut.tap[7].b, 0);
        check("taps_ones", ones, 4);
        collect(1'b0, bits, lasts, nbits, cycles);
        check("w3c_bits", bits, frame_of(8'h3C));
        check("taps_hold", tapv, 8'h3C);

`ifdef WORD_SERIALIZER_PARITY_EN
        send(8'h07);
        collect(1'b0, bits, lasts, nbits, cycles);
        check("par_nbits", nbits, 9);
        check("par_bits", bits, 9'h107);
        check("par_lasts", lasts, 9'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
